output_display: RTL

OUTPUT_DISPLAY -- requirements
Module: output_display

---
 rtl/output_display.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/output_display.sv
// ---------------------------------------------------------------------------
// output_display
//   Captures an 8-bit value (unsigned or two's complement) and converts it to
//   decimal with a sequential double-dabble engine, one shift-plus-add-3 step
//   per clock for 8 clocks. A free-running scanner then multiplexes the four
//   digits onto a common-anode style 7-segment display.
//
//   Build option: define OUTPUT_DISPLAY_BLANK_EN to blank leading zeros on the
//   hundreds and tens digits. The units digit is always shown and the minus
//   sign always sits on digit 3.
//
// Parameters
//   SCAN_DIV     clock cycles each digit is driven per scan step (>= 2)
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          synchronous, active-high reset
//   value        binary value to display
//   signed_mode  1 = value is two's complement, 0 = unsigned
//   load         single-cycle capture request (ignored while busy)
//   busy         high while a captured value is being converted
//   io_seg       active-low segments, bit0..6 = a..g, bit7 = dp (registered)
//   io_sel       active-low digit select, bit0 = rightmost digit (registered)
// ---------------------------------------------------------------------------
module output_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       signed_mode,
  input  logic       load,
  output logic       busy,
  output logic [7:0] io_seg,
  output logic [3:0] io_sel
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Display contents for "unsigned 0", loaded on reset.
`ifdef OUTPUT_DISPLAY_BLANK_EN
  localparam logic [3:0][7:0] DISP_ZERO = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
`else
  localparam logic [3:0][7:0] DISP_ZERO = {8'hFF, 8'hC0, 8'hC0, 8'hC0};
`endif

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CONV
  } state_t;

  // Active-low segment code for one decimal digit, dp kept off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // -------------------------------------------------------------------------
  // Conversion state
  // -------------------------------------------------------------------------
  state_t          state_q;
  logic            busy_q;
  logic [2:0]      iter_q;
  logic [7:0]      bin_q, bin_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            neg_q;
  logic [3:0][7:0] dig_q, dig_d;

  logic            neg_in;
  logic [7:0]      mag_in;
  logic [11:0]     bcd_adj;
  logic [3:0]      hund, tens, units;

  // Capture-side magnitude. The negation is done in 8 bits and then treated
  // as unsigned, so 8'h80 becomes 128; the 9th magnitude bit is always 0 and
  // therefore not stored.
  always_comb begin
    neg_in = signed_mode & value[7];
    mag_in = neg_in ? 8'(~value + 8'd1) : value;
  end

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift
  // the combined {bcd, bin} register left by one.
  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_d   = {bcd_adj[10:0], bin_q[7]};
    bin_d   = {bin_q[6:0], 1'b0};
  end

  // Digit images built from the result of the final iteration.
  always_comb begin
    hund  = bcd_d[11:8];
    tens  = bcd_d[7:4];
    units = bcd_d[3:0];
    dig_d = '1;
    dig_d[3] = neg_q ? SEG_MINUS : SEG_BLANK;
    dig_d[2] = seg7(hund);
    dig_d[1] = seg7(tens);
    dig_d[0] = seg7(units);
`ifdef OUTPUT_DISPLAY_BLANK_EN
    if (hund == 4'd0) begin
      dig_d[2] = SEG_BLANK;
      if (tens == 4'd0) begin
        dig_d[1] = SEG_BLANK;
      end
    end
`endif
  end

  // Conversion FSM. Displayed digits are only written on the last iteration,
  // so the previous value stays visible while a conversion runs and a reset
  // mid-conversion never exposes a partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      iter_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      dig_q   <= DISP_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q <= ST_CONV;
            busy_q  <= 1'b1;
            iter_q  <= '0;
            bin_q   <= mag_in;
            bcd_q   <= '0;
            neg_q   <= neg_in;
          end
        end
        ST_CONV: begin
          bin_q  <= bin_d;
          bcd_q  <= bcd_d;
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'd7) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dig_q   <= dig_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // -------------------------------------------------------------------------
  // Free-running digit scanner
  // -------------------------------------------------------------------------
  logic [CW-1:0] scan_cnt_q;
  logic [1:0]    idx_q;
  logic [7:0]    io_seg_q;
  logic [3:0]    io_sel_q;
  logic          scan_wrap;

  always_comb begin
    scan_wrap = (scan_cnt_q == CW'(SCAN_DIV - 1));
  end

  // Segments and select are both registered from the current index, so they
  // always change together; the output pair trails the index by one cycle,
  // which gives each digit exactly SCAN_DIV cycles on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      io_seg_q   <= '1;
      io_sel_q   <= '1;
    end else begin
      if (scan_wrap) begin
        scan_cnt_q <= '0;
        idx_q      <= idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + CW'(1);
      end
      io_seg_q <= dig_q[idx_q];
      io_sel_q <= ~(4'b0001 << idx_q);
    end
  end

  assign io_seg = io_seg_q;
  assign io_sel = io_sel_q;

endmodule
